// File: rtl/md_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_pkg : shared op encodings, FSM states and helpers for md_unit          |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
package md_pkg;

    localparam logic [2:0] c_OP_MULTU = 3'b000;
    localparam logic [2:0] c_OP_MULT  = 3'b001;
    localparam logic [2:0] c_OP_DIVU  = 3'b010;
    localparam logic [2:0] c_OP_DIV   = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    localparam int c_ITER  = 32;
    localparam int c_CNT_W = $clog2(c_ITER);
    localparam logic [c_CNT_W-1:0] c_LAST_ITER = c_CNT_W'(c_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } md_state_t;

    function automatic logic [31:0] f_abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [31:0] f_cneg32(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    function automatic logic [63:0] f_cneg64(input logic [63:0] x, input logic neg);
        return neg ? (~x + 64'd1) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_div_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_div_core : 32-iteration unsigned restoring divider, one bit per clock  |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module md_div_core
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        valid
);

    logic               r_active;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_div;

    logic [32:0]        w_shift;
    logic               w_fits;
    logic [31:0]        w_diff;
    logic [31:0]        w_rem_next;
    logic [31:0]        w_quo_next;

    // A zero divisor always "fits", which yields an all-ones quotient and
    // returns the dividend as the remainder without special casing.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_fits     = (w_shift >= {1'b0, r_div});
    assign w_diff     = w_shift[31:0] - r_div;
    assign w_rem_next = w_fits ? w_diff : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_fits};

    // Results are presented combinationally during the final iteration so the
    // parent can capture them on the same edge that ends the iteration.
    assign valid     = r_active && (r_cnt == c_LAST_ITER);
    assign quotient  = w_quo_next;
    assign remainder = w_rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
        end else if (start && !r_active) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= dividend;
            r_div    <= divisor;
        end else if (r_active) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (r_cnt == c_LAST_ITER) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | md_unit : iterative HI/LO multiply/divide unit with MTHI/MTLO moves       |
// | Rev 1.0 : initial release                                                 |
// +--------------------------------------------------------------------------+
module md_unit
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t          r_state;
    md_state_t          w_next;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_signed;
    logic [31:0]        w_opa;
    logic [31:0]        w_opb;

    logic [31:0]        r_mcand;
    logic [63:0]        r_prod;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg_p;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic [32:0]        w_sum;
    logic [63:0]        w_prod_next;
    logic [63:0]        w_mul_res;
    logic               w_mul_last;

    logic               w_div_valid;
    logic               w_div_last;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic [31:0]        w_div_hi;
    logic [31:0]        w_div_lo;

    assign w_accept = start && (r_state == S_IDLE);
    assign w_is_mul = (op == c_OP_MULTU) || (op == c_OP_MULT);
    assign w_is_div = (op == c_OP_DIVU)  || (op == c_OP_DIV);
    assign w_signed = (op == c_OP_MULT)  || (op == c_OP_DIV);
    assign w_opa    = w_signed ? f_abs32(a) : a;
    assign w_opb    = w_signed ? f_abs32(b) : b;

    // Radix-2 shift-add: the multiplier sits in the low half of r_prod and is
    // consumed one bit per cycle while partial sums shift in from the top.
    assign w_sum       = {1'b0, r_prod[63:32]} + {1'b0, (r_prod[0] ? r_mcand : 32'd0)};
    assign w_prod_next = {w_sum, r_prod[31:1]};
    assign w_mul_last  = (r_state == S_MUL) && (r_cnt == c_LAST_ITER);
    assign w_mul_res   = f_cneg64(w_prod_next, r_neg_p);

    md_div_core u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_accept && w_is_div),
        .dividend  (w_opa),
        .divisor   (w_opb),
        .quotient  (w_quo),
        .remainder (w_rem),
        .valid     (w_div_valid)
    );

    assign w_div_last = (r_state == S_DIV) && w_div_valid;
    assign w_div_hi   = f_cneg32(w_rem, r_neg_r);
    assign w_div_lo   = f_cneg32(w_quo, r_neg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_next = S_MUL;
                end else if (w_accept && w_is_div) begin
                    w_next = S_DIV;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (r_cnt == c_LAST_ITER) begin
                    w_next = S_DONE;
                end
            end
            S_DIV: begin
                busy = 1'b1;
                if (w_div_valid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sign flags are captured at accept so later operand changes are harmless.
    // A zero divisor keeps the quotient all-ones and lets the remainder sign
    // restore the original dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_neg_p <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept && w_is_mul) begin
            r_mcand <= w_opa;
            r_prod  <= {32'd0, w_opb};
            r_cnt   <= '0;
            r_neg_p <= w_signed & (a[31] ^ b[31]);
        end else if (w_accept && w_is_div) begin
            r_neg_q <= w_signed & (a[31] ^ b[31]) & (b != 32'd0);
            r_neg_r <= w_signed & a[31];
        end else if (r_state == S_MUL) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_accept && (op == c_OP_MTHI)) begin
            r_hi <= a;
        end else if (w_accept && (op == c_OP_MTLO)) begin
            r_lo <= a;
        end else if (w_mul_last) begin
            r_hi <= w_mul_res[63:32];
            r_lo <= w_mul_res[31:0];
        end else if (w_div_last) begin
            r_hi <= w_div_hi;
            r_lo <= w_div_lo;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have exactly one clock and the ports below; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request strobe; sampled on rising clk.
REQ-005 op  input  3  operation: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 a  input  32  operand A: multiplicand, dividend, or MTHI/MTLO source.
REQ-007 b  input  32  operand B: multiplier or divisor.
REQ-008 busy  output  1  high while a multi-cycle operation is in progress.
REQ-009 done  output  1  one-cycle pulse in the cycle HI/LO take a MULT/DIV result.
REQ-010 hi  output  32  HI register, registered output.
REQ-011 lo  output  32  LO register, registered output.

Function
REQ-012 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-013 In IDLE, start with op MULT/MULTU SHALL latch a and b and enter MUL; with op DIV/DIVU, latch and enter DIV.
REQ-014 In IDLE, start with MTHI SHALL load hi<=a at that edge, and MTLO SHALL load lo<=a; the FSM stays in IDLE and busy/done stay low.
REQ-015 start with a reserved op SHALL be ignored.
REQ-016 start while busy=1 SHALL be ignored; operands SHALL NOT be re-latched.
REQ-017 busy SHALL go high on the edge that accepts a MULT/DIV and stay high through the last MUL/DIV iteration.
REQ-018 MUL and DIV SHALL each take exactly 32 iterations, one per cycle: radix-2 shift-add and restoring shift-subtract.
REQ-019 After the 32nd iteration the FSM SHALL enter DONE: hi/lo update, done=1, busy=0, then IDLE on the next edge.
REQ-020 Accept-to-done latency SHALL be 33 cycles; a new start SHALL be accepted in the DONE cycle's following edge (IDLE).
REQ-021 MULTU SHALL produce the unsigned 64-bit product: {hi,lo}=a*b.
REQ-022 MULT SHALL produce the two's-complement 64-bit product, computed on magnitudes with the sign fixed at DONE.
REQ-023 DIVU SHALL give lo=a/b and hi=a%b, both unsigned.
REQ-024 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the dividend's sign.
REQ-025 For division by zero (DIV or DIVU), the result SHALL be lo=32'hFFFFFFFF and hi=a, still after 33 cycles.
REQ-026 For DIV with a=32'h80000000 and b=32'hFFFFFFFF, the result SHALL be lo=32'h80000000 and hi=0.
REQ-027 hi/lo SHALL hold their value between updates; no partial result SHALL ever be visible on hi/lo.
REQ-028 Operands changing after acceptance SHALL NOT affect the result.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, and clear all iteration state, including mid-operation.
REQ-030 After rst_n deasserts, the first start on a clean rising edge SHALL be accepted normally.

Structure
REQ-031 A shared package md_pkg SHALL hold the op encodings, the FSM state enumeration, and the iteration count constant (32).
REQ-032 The iterative divider SHALL be a sub-module md_div_core (start, dividend, divisor, 32-bit quotient/remainder, valid) instantiated once.
REQ-033 The multiplier datapath and sign handling SHALL stay in md_unit.

Verification
REQ-034 MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> at done: hi=32'hFFFFFFFE, lo=32'h00000001; done exactly 33 cycles after accept.
REQ-035 MULT a=-3, b=7, then DIV a=-7, b=2 -> {hi,lo}=64'hFFFFFFFF_FFFFFFEB; then lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-036 DIVU a=100, b=0; then DIV a=32'h80000000, b=-1 -> lo=32'hFFFFFFFF, hi=100; then lo=32'h80000000, hi=0.
REQ-037 Start DIVU 100/7, pulse start with MULTU 2*3 at cycle 5, change a/b every cycle -> single done; lo=14, hi=2.
REQ-038 MTHI a=32'h12345678, then MTLO a=32'h9ABCDEF0 -> hi/lo updated next edge; busy and done never high.
REQ-039 Start MULT, assert rst_n=0 at cycle 10, release, then MULTU 5*6 -> hi/lo/busy/done=0 during reset; then lo=30, hi=0 after 33 cycles.
